// File: rtl/elevator_shaft.sv
// Car and shaft responder: models car travel between four floors and the door-dwell
// timer in response to the controller's motor command.
module elevator_shaft #(
    parameter int TRAVEL_CYCLES = 16,
    parameter int DWELL_CYCLES  = 32,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] motor,
    output logic [1:0] floor,
    output logic       at_floor,
    output logic       arrive,
    output logic       timer,
    output logic       fault
);

    localparam logic [CNT_W-1:0] ZERO        = CNT_W'(0);
    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_MAX   = CNT_W'(DWELL_CYCLES);

    localparam logic [1:0] CMD_REST = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;
    localparam logic [1:0] CMD_WAIT = 2'b11;

    logic [1:0]       level_r, level_s;
    logic [CNT_W-1:0] offset_r, offset_s;
    logic [1:0]       floor_r, floor_s;
    logic             arrive_r, arrive_s;
    logic             fault_r, fault_s;
    logic [CNT_W-1:0] dwell_r, dwell_s;
    logic             aligned_s;

    assign aligned_s = (offset_r == ZERO);

    // Next-state computation for position, arrival, fault and dwell count.
    always_comb begin
        level_s  = level_r;
        offset_s = offset_r;
        floor_s  = floor_r;
        arrive_s = 1'b0;
        fault_s  = fault_r;
        dwell_s  = ZERO;
        case (motor)
            CMD_UP: begin
                if ((level_r == 2'd3) && aligned_s) begin
                    fault_s = 1'b1;
                end else if (offset_r == TRAVEL_LAST) begin
                    level_s  = level_r + 2'd1;
                    offset_s = ZERO;
                    floor_s  = level_r + 2'd1;
                    arrive_s = 1'b1;
                end else begin
                    offset_s = offset_r + ONE;
                end
            end
            CMD_DOWN: begin
                if ((level_r == 2'd0) && aligned_s) begin
                    fault_s = 1'b1;
                end else if (aligned_s) begin
                    // Leaving a floor downward: the car is now below it, in the lower span.
                    level_s  = level_r - 2'd1;
                    offset_s = TRAVEL_LAST;
                end else if (offset_r == ONE) begin
                    offset_s = ZERO;
                    floor_s  = level_r;
                    arrive_s = 1'b1;
                end else begin
                    offset_s = offset_r - ONE;
                end
            end
            CMD_WAIT: begin
                if (!aligned_s) begin
                    fault_s = 1'b1;
                end else if (dwell_r == DWELL_MAX) begin
                    dwell_s = DWELL_MAX;
                end else begin
                    dwell_s = dwell_r + ONE;
                end
            end
            CMD_REST: begin
                dwell_s = ZERO;
            end
            default: begin
                dwell_s = ZERO;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_r  <= 2'd0;
            offset_r <= ZERO;
            floor_r  <= 2'd0;
            arrive_r <= 1'b0;
            fault_r  <= 1'b0;
            dwell_r  <= ZERO;
        end else begin
            level_r  <= level_s;
            offset_r <= offset_s;
            floor_r  <= floor_s;
            arrive_r <= arrive_s;
            fault_r  <= fault_s;
            dwell_r  <= dwell_s;
        end
    end

    assign floor    = floor_r;
    assign at_floor = aligned_s;
    assign arrive   = arrive_r;
    assign timer    = (dwell_r == DWELL_MAX);
    assign fault    = fault_r;

endmodule
